// File: rtl/cmov_copy.sv
// Constant-time conditional copy: every word is read from both source buffers
// and one of them is written to the destination through a mask-based select.
module cmov_copy (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  ilen,
    input  logic        sel,
    output logic [8:0]  rd_address,
    output logic        rd_base_sel,
    input  logic [63:0] din,
    output logic [8:0]  wr_address,
    output logic        wr_en,
    output logic [63:0] dout,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  i_reg;
    logic [9:0]  ilen_reg;
    logic        sel_reg;
    logic [63:0] a_reg, b_reg;
    logic [8:0]  wr_address_reg;
    logic [63:0] dout_reg;

    logic        accept;
    logic [9:0]  ilen_sat;
    logic [9:0]  i_inc;
    logic [63:0] sel_mask;
    logic [63:0] wr_data;

    assign accept   = ((state_reg == IDLE) || (state_reg == DONE)) && start;
    assign ilen_sat = (ilen > 10'd512) ? 10'd512 : ilen;
    assign i_inc    = i_reg + 10'd1;

    // Branch-free select so the data path never depends on sel timing-wise.
    assign sel_mask = {64{sel_reg}};
    assign wr_data  = (sel_mask & a_reg) | (~sel_mask & b_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (ilen_sat == 10'd0) ? DONE : RDA;
                end
            end
            RDA:     state_next = RDB;
            RDB:     state_next = CAP;
            CAP:     state_next = WR;
            WR:      state_next = (i_inc == ilen_reg) ? DONE : RDA;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            i_reg          <= 10'd0;
            ilen_reg       <= 10'd0;
            sel_reg        <= 1'b0;
            a_reg          <= 64'd0;
            b_reg          <= 64'd0;
            wr_address_reg <= 9'd0;
            dout_reg       <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                ilen_reg <= ilen_sat;
                sel_reg  <= sel;
                i_reg    <= 10'd0;
            end
            if (state_reg == RDB) begin
                a_reg <= din;
            end
            if (state_reg == CAP) begin
                b_reg <= din;
            end
            // Capture the presented write so address/data hold outside WR.
            if (state_reg == WR) begin
                i_reg          <= i_inc;
                wr_address_reg <= i_reg[8:0];
                dout_reg       <= wr_data;
            end
        end
    end

    assign rd_address  = i_reg[8:0];
    assign rd_base_sel = (state_reg == RDB);
    assign wr_en       = (state_reg == WR);
    assign wr_address  = wr_en ? i_reg[8:0] : wr_address_reg;
    assign dout        = wr_en ? wr_data : dout_reg;
    assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_cmov_copy.sv
// Directed bench for cmov_copy: synchronous RAM models for A, B and the
// destination, a write log, and hand-computed cycle/address/data expectations.
module tb_cmov_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  ilen;
    logic        sel;
    logic [8:0]  rd_address;
    logic        rd_base_sel;
    logic [63:0] din;
    logic [8:0]  wr_address;
    logic        wr_en;
    logic [63:0] dout;
    logic        done;

    always #5 clk = ~clk;

    cmov_copy dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ilen        (ilen),
        .sel         (sel),
        .rd_address  (rd_address),
        .rd_base_sel (rd_base_sel),
        .din         (din),
        .wr_address  (wr_address),
        .wr_en       (wr_en),
        .dout        (dout),
        .done        (done)
    );

    logic [63:0] mem_a [512];
    logic [63:0] mem_b [512];
    logic [63:0] dest  [512];

    int          cyc = 0;
    int          wr_count = 0;
    int          wr_addr_log [1024];
    int          wr_cyc_log  [1024];
    logic [63:0] wr_data_log [1024];

    logic [10:0] trace_cur [64];
    logic [10:0] trace_ref [64];
    int          trace_len;
    int          trace_ref_len;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory models and write logger; cycle c ends at the edge where cyc == c.
    always @(posedge clk) begin
        din <= rd_base_sel ? mem_b[rd_address] : mem_a[rd_address];
        if (wr_en && wr_count < 1024) begin
            wr_addr_log[wr_count] = int'(wr_address);
            wr_cyc_log[wr_count]  = cyc;
            wr_data_log[wr_count] = dout;
            dest[wr_address]      = dout;
            wr_count              = wr_count + 1;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic clear_dest();
        for (int k = 0; k < 512; k++) dest[k] = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Start a copy; optionally pulse start again glitch_at cycles into the run.
    task automatic run_copy(input logic [9:0] len, input logic s, input int limit,
                            input int glitch_at, output int t0, output int base,
                            output int done_cyc);
        @(negedge clk);
        ilen  = len;
        sel   = s;
        start = 1'b1;
        t0    = cyc;
        base  = wr_count;
        @(negedge clk);
        start     = 1'b0;
        done_cyc  = -1;
        trace_len = 0;
        for (int k = 0; k < limit; k++) begin
            if (trace_len < 64) begin
                trace_cur[trace_len] = {wr_en, rd_base_sel, rd_address};
                trace_len++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (k == glitch_at) begin
                start = 1'b1;
                ilen  = 10'd1;
                sel   = ~s;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("run_timeout", 64'(done_cyc < 0), 64'd0);
    endtask

    task automatic verify(input string tag, input int t0, input int base,
                          input int n, input logic s);
        int          errs;
        logic [63:0] exp;
        errs = 0;
        check({tag, "_count"}, 64'(wr_count - base), 64'(n));
        for (int k = 0; k < n && base + k < wr_count; k++) begin
            exp = s ? mem_a[k] : mem_b[k];
            if (wr_addr_log[base + k] != k) errs++;
            if (wr_cyc_log[base + k] - t0 != 4 + 4 * k) errs++;
            if (wr_data_log[base + k] !== exp) errs++;
            if (dest[k] !== exp) errs++;
        end
        check({tag, "_writes"}, 64'(errs), 64'd0);
    endtask

    int t0, base, dcyc, diffs;

    initial begin
        for (int k = 0; k < 512; k++) begin
            mem_a[k] = 64'(k);
            mem_b[k] = 64'hFFFF_0000_0000_0000 + 64'(k);
        end
        clear_dest();
        rst   = 1'b1;
        start = 1'b0;
        ilen  = 10'd0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done",        64'(done),        64'd0);
        check("rst_wr_en",       64'(wr_en),       64'd0);
        check("rst_rd_address",  64'(rd_address),  64'd0);
        check("rst_rd_base_sel", 64'(rd_base_sel), 64'd0);
        check("rst_wr_address",  64'(wr_address),  64'd0);
        check("rst_dout",        dout,             64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Four words, sel = 1 -> A
        run_copy(10'd4, 1'b1, 100, -1, t0, base, dcyc);
        check("sel1_done_cycle", 64'(dcyc - t0), 64'd17);
        verify("sel1", t0, base, 4, 1'b1);
        for (int k = 0; k < 64; k++) trace_ref[k] = trace_cur[k];
        trace_ref_len = trace_len;

        // Same buffers, sel = 0 -> B, identical control trace
        clear_dest();
        run_copy(10'd4, 1'b0, 100, -1, t0, base, dcyc);
        check("sel0_done_cycle", 64'(dcyc - t0), 64'd17);
        verify("sel0", t0, base, 4, 1'b0);
        diffs = 0;
        for (int k = 0; k < trace_len && k < 64; k++)
            if (trace_cur[k] !== trace_ref[k]) diffs++;
        check("trace_len", 64'(trace_len), 64'(trace_ref_len));
        check("trace_diffs", 64'(diffs), 64'd0);

        // Zero length: done after one cycle, no writes
        run_copy(10'd0, 1'b1, 20, -1, t0, base, dcyc);
        check("len0_done_cycle", 64'(dcyc - t0), 64'd1);
        check("len0_writes", 64'(wr_count - base), 64'd0);
        check("len0_rd_address", 64'(rd_address), 64'd0);

        // Oversized length saturates to 512
        clear_dest();
        run_copy(10'd600, 1'b1, 2200, -1, t0, base, dcyc);
        check("len600_done_cycle", 64'(dcyc - t0), 64'd2049);
        verify("len600", t0, base, 512, 1'b1);

        // Reset during CAP of word 2
        clear_dest();
        @(negedge clk);
        ilen  = 10'd4;
        sel   = 1'b1;
        start = 1'b1;
        t0    = cyc;
        base  = wr_count;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && cyc < t0 + 11; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_wr_en",       64'(wr_en),       64'd0);
        check("abort_done",        64'(done),        64'd0);
        check("abort_rd_address",  64'(rd_address),  64'd0);
        check("abort_rd_base_sel", 64'(rd_base_sel), 64'd0);
        check("abort_wr_address",  64'(wr_address),  64'd0);
        check("abort_dout",        dout,             64'd0);
        repeat (8) @(negedge clk);
        verify("abort", t0, base, 2, 1'b1);
        check("abort_no_addr2", dest[2], 64'hDEAD_BEEF_DEAD_BEEF);
        clear_dest();
        run_copy(10'd3, 1'b0, 100, -1, t0, base, dcyc);
        check("after_abort_done_cycle", 64'(dcyc - t0), 64'd13);
        verify("after_abort", t0, base, 3, 1'b0);

        // Start during a copy is ignored; start in DONE restarts
        clear_dest();
        run_copy(10'd3, 1'b1, 100, 3, t0, base, dcyc);
        check("glitch_done_cycle", 64'(dcyc - t0), 64'd13);
        verify("glitch", t0, base, 3, 1'b1);
        clear_dest();
        run_copy(10'd2, 1'b0, 100, -1, t0, base, dcyc);
        check("restart_done_cycle", 64'(dcyc - t0), 64'd9);
        verify("restart", t0, base, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
